ps2_frame_rx: RTL and testbench
===============================

Name: ps2_frame_rx

Overview:
Receives raw PS/2 device-to-host frames from the keyboard pins and delivers each byte as a one-cycle strobe. It sits directly upstream of the key decoder that drives the paddle `left`/`right` signals. Its job is to separate electrical handling (synchronisation, glitch filtering, framing, parity, timeout) from scancode interpretation, so the decoder only ever sees clean, checked bytes.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each pin input; minimum 2.
- FILTER_LEN, 8, consecutive equal samples of synced ps2_clk needed to change the filtered level.
- TIMEOUT_CYCLES, 100000, idle clk cycles allowed between falling edges inside a frame (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- data  out  8  last correctly received byte.
- valid  out  1  one-cycle pulse; data is updated in the same cycle.
- parity_err  out  1  one-cycle pulse: frame had bad odd parity.
- frame_err  out  1  one-cycle pulse: bad stop bit, or timeout.

Behaviour:
- Clocking and reset: one clock domain, clk. rst is synchronous and active-high; no logic uses an asynchronous reset.
- Reset values: data=0x00; valid, parity_err and frame_err = 0; FSM in IDLE; bit counter 0; synchroniser and filter flops 1 (bus idle high); timeout counter 0.
- Synchronisation: each pin passes through SYNC_STAGES flops.
- Clock filter: a FILTER_LEN shift register on synced ps2_clk. The filtered level goes to 0 only when all bits are 0 and to 1 only when all bits are 1; otherwise it holds.
- Falling edge: fall = filt_q & ~filt, one cycle wide. Synced ps2_data is sampled on that cycle; data is stable through the clock-low half.
- Frame format: start bit (0), 8 data bits LSB first, odd parity, stop bit (1).
- FSM states:
  - IDLE: on fall, if data=0 go to DATA with cnt=0. If data=1, stay in IDLE with no error.
  - DATA: on fall, shreg[cnt] <= data and cnt++. After cnt reaches 7, go to PARITY.
  - PARITY: on fall, latch the bit and go to STOP.
  - STOP: on fall, return to IDLE and check the frame in this order:
    1. stop bit = 0: frame_err pulses; data is unchanged.
    2. otherwise, if ^{shreg, parity} = 0: parity_err pulses; data is unchanged.
    3. otherwise: data <= shreg and valid pulses.
- Output pulses: registered, assert the cycle after the stop-bit fall, last exactly 1 cycle, and are mutually exclusive.
- Latency: from a clean falling edge of raw ps2_clk (the stop-bit edge) to valid high is exactly SYNC_STAGES+FILTER_LEN+2 clk cycles.
- Back-to-back frames: a new start bit may follow the stop bit immediately. No frame is lost while valid is high.
- Timeout: the counter clears on every fall and in IDLE, and increments otherwise. In any state other than IDLE, reaching TIMEOUT_CYCLES pulses frame_err, returns the FSM to IDLE and discards the partial byte.
- Reset mid-frame: the partial frame is discarded and no pulse is generated. The remaining edges of that frame start no frame unless a sampled 0 is taken as a start bit; any such misalignment is recovered by the timeout or by the next frame check.
- Host-to-device transmission is out of scope; both pins are input-only.

Optional Feature:
- PS2_RX_TIMEOUT_EN.
- Defined: the timeout counter and abort logic are built as described above.
- Undefined: no counter is built and TIMEOUT_CYCLES is ignored. A partial frame waits indefinitely for further edges, and frame_err is raised only for a bad stop bit.

Decomposition:
- Package ps2_pkg holds:
  - the state encoding: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3;
  - DATA_BITS=8;
  - the key codes used downstream: BREAK=8'hF0, EXT=8'hE0.
- Sub-module ps2_line_filter (synchroniser plus FILTER_LEN glitch filter plus fall-edge output) is instantiated once, for ps2_clk. ps2_data uses a plain synchroniser.

Test Plan:
- Good frame: send 0x1C with parity 0 and stop 1 -> after exactly 12 cycles from the stop edge (default parameters), valid pulses for 1 cycle, data=0x1C, no error pulses.
- Bad parity: send 0x1C with parity 1 -> parity_err pulses once; valid stays 0; data keeps its previous value (0x00 after reset).
- Bad stop bit: send 0x75 with stop=0 -> frame_err pulses once, data unchanged. A following good 0x75 frame -> valid pulses, data=0x75.
- Glitch rejection: insert a 3-cycle low pulse on ps2_clk mid-bit during an 0x6B frame -> no extra bit is shifted; data=0x6B with valid.
- Timeout: with TIMEOUT_CYCLES=2000 overridden, send 5 bits then stall 2001 cycles -> frame_err pulses once. A following 0xF0 frame -> valid with data=0xF0. With PS2_RX_TIMEOUT_EN undefined, the same stall gives no pulse.
- Back-to-back and reset: E0, 6B sent with zero gap -> two valid pulses, data sequence E0 then 6B. Assert rst for 1 cycle after 4 bits of a frame -> no pulse, outputs at reset values, next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame width and downstream key codes for the PS/2 receiver
package ps2_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;
    localparam int DATA_BITS = 8;
    localparam logic [7:0] BREAK = 8'hF0;
    localparam logic [7:0] EXT   = 8'hE0;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronises a raw pin, rejects glitches shorter than FILTER_LEN cycles, flags falling edges
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic [FILTER_LEN-1:0]  sh;
    logic                   level;
    logic                   level_q;

    // sync chain, filter window and hysteretic level; everything idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= '1;
            sh      <= '1;
            level   <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], pin};
            sh      <= {sh[FILTER_LEN-2:0], sync[SYNC_STAGES-1]};
            level   <= (sh == '0) ? 1'b0 : (&sh) ? 1'b1 : level;
            level_q <= level;
        end
    end

    assign fall = level_q & ~level;
endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver with parity/stop checks; PS2_RX_TIMEOUT_EN adds an inter-edge timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err
);
    logic                   fall;
    logic                   sd;
    logic [SYNC_STAGES-1:0] dsync;
    logic                   timeout;
    state_t                 state;
    logic [2:0]             cnt;
    logic [7:0]             shreg;
    logic                   par;

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk (clk),
        .rst (rst),
        .pin (ps2_clk),
        .fall(fall)
    );

    // data pin only needs synchronising: it is sampled mid clock-low
    always_ff @(posedge clk) begin
        if (rst) dsync <= '1;
        else     dsync <= {dsync[SYNC_STAGES-2:0], ps2_data};
    end

    assign sd = dsync[SYNC_STAGES-1];

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    // idle time since the last falling edge while a frame is in progress
    always_ff @(posedge clk) begin
        if (rst || fall || state == IDLE) tcnt <= '0;
        else if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
    end

    assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));
`else
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // frame FSM with registered one-cycle result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!sd) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        shreg[cnt] <= sd;
                        cnt        <= cnt + 3'd1;
                        if (cnt == 3'(DATA_BITS - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= sd;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!sd) frame_err <= 1'b1;
                        else if (!(^{shreg, par})) parity_err <= 1'b1;
                        else begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: randomized PS/2 frames checked against a bit-list frame model
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int TO   = 2000;
    localparam int HALF = 40;
    localparam int LAT  = 12;
`ifdef PS2_RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        int         kind;
        logic [7:0] dat;
        bit         lat;
        int         ref_cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic       valid, parity_err, frame_err;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    ev_t        expq[$];
    bit         bits_q[$];
    logic [7:0] exp_data = 8'h00;
    ev_t        mon_e;
    int         mon_k;
    bit         prev_pulse = 1'b0;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data      (data),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference: collect sampled bits from a start bit; every 11 bits form one judged frame
    task automatic model_bit(input bit b);
        if (bits_q.size() == 0 && b) return;
        bits_q.push_back(b);
        if (bits_q.size() == 11) begin
            ev_t        e;
            logic [7:0] by;
            int         ones;
            ones = 0;
            for (int i = 0; i < 8; i++) by[i] = bits_q[i+1];
            for (int i = 1; i < 10; i++) ones += int'(bits_q[i]);
            e.lat     = 1'b1;
            e.ref_cyc = cyc;
            if (!bits_q[10]) e.kind = 2;
            else if (ones % 2 == 0) e.kind = 1;
            else begin
                e.kind   = 0;
                exp_data = by;
            end
            e.dat = exp_data;
            expq.push_back(e);
            bits_q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input bit glitch);
        @(negedge clk);
        ps2_data = b;
        if (glitch) begin
            idle(15);
            ps2_clk = 1'b0;
            idle(3);
            ps2_clk = 1'b1;
            idle(HALF - 18);
        end else idle(HALF);
        ps2_clk = 1'b0;
        model_bit(b);
        idle(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_bit, input int nbits);
        bit fr[11];
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = b[i];
        fr[9]  = ~(^b) ^ bad_par;
        fr[10] = ~bad_stop;
        for (int i = 0; i < nbits; i++) send_bit(fr[i], i == glitch_bit);
    endtask

    task automatic stall();
        if (TO_EN && bits_q.size() != 0) begin
            ev_t e;
            e.kind    = 2;
            e.dat     = exp_data;
            e.lat     = 1'b0;
            e.ref_cyc = 0;
            expq.push_back(e);
            bits_q.delete();
        end
        idle(TO + 300);
    endtask

    task automatic check_reset_outputs();
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
    endtask

    // pulse monitor: each pulse must be one-hot, one cycle wide and match the next model event
    always @(negedge clk) begin
        if (rst) prev_pulse = 1'b0;
        else if (valid | parity_err | frame_err) begin
            mon_k = valid ? 0 : parity_err ? 1 : 2;
            check("one_hot", $countones({valid, parity_err, frame_err}), 1);
            check("width", prev_pulse, 0);
            if (expq.size() == 0) check("spurious", mon_k, 99);
            else begin
                mon_e = expq.pop_front();
                check("kind", mon_k, mon_e.kind);
                check("data", data, mon_e.dat);
                if (mon_e.lat) check("latency", cyc - mon_e.ref_cyc, LAT);
            end
            prev_pulse = 1'b1;
        end else prev_pulse = 1'b0;
    end

    initial begin
        int  n;
        int  g;
        logic [7:0] b;
        rst = 1'b1;
        idle(5);
        rst = 1'b0;
        check_reset_outputs();
        idle(20);
        send_frame(8'h1C, 1'b0, 1'b0, -1, 11);
        idle(30);
        send_frame(8'h1C, 1'b1, 1'b0, -1, 11);
        idle(30);
        send_frame(8'h75, 1'b0, 1'b1, -1, 11);
        idle(30);
        send_frame(8'h75, 1'b0, 1'b0, -1, 11);
        idle(30);
        send_frame(8'h6B, 1'b0, 1'b0, 4, 11);
        idle(30);
        send_frame(8'h5A, 1'b0, 1'b0, -1, 5);
        stall();
        send_frame(BREAK, 1'b0, 1'b0, -1, 11);
        idle(30);
        send_frame(EXT, 1'b0, 1'b0, -1, 11);
        send_frame(8'h6B, 1'b0, 1'b0, -1, 11);
        idle(30);
        send_frame(8'h33, 1'b0, 1'b0, -1, 4);
        idle(30);
        rst = 1'b1;
        bits_q.delete();
        exp_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        idle(20);
        send_frame(8'h29, 1'b0, 1'b0, -1, 11);
        idle(30);
        for (int i = 0; i < 25; i++) begin
            b = 8'($urandom);
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : 11;
            send_frame(b, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, g, n);
            if (n < 11) stall();
            else idle(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 200)));
        end
        idle(100);
        check("drain", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
